alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc.sv | 135 +++++++++++++
 tb/tb_alu_mc.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle add/sub/logic/shift ops, shift-add multiply over WIDTH cycles.
// Result and {C,V,N,Z} flags are held in DONE until the consumer accepts them.
module alu_mc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic [3:0]       flags
);
    localparam int SW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   o_reg, o_next;
    logic [3:0]         flags_reg, flags_next;
    logic [2*WIDTH-1:0] acc_reg, acc_next;
    logic [2*WIDTH-1:0] mcand_reg, mcand_next;
    logic [WIDTH-1:0]   mplier_reg, mplier_next;
    logic [SW-1:0]      cnt_reg, cnt_next;

    logic [WIDTH:0]     sum, diff;
    logic [SW-1:0]      shamt;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_v;
    logic [2*WIDTH-1:0] acc_step;

    // Single-cycle datapath, evaluated on the live inputs and used only at the accept edge.
    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};
        shamt   = b[SW-1:0];
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        unique case (op)
            3'd0: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            3'd1: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            3'd2:    alu_res = a & b;
            3'd3:    alu_res = a | b;
            3'd4:    alu_res = a ^ b;
            3'd5:    alu_res = a << shamt;
            3'd6:    alu_res = a >> shamt;
            default: alu_res = '0;
        endcase
    end

    assign acc_step = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;

    always_comb begin
        state_next  = state_reg;
        o_next      = o_reg;
        flags_next  = flags_reg;
        acc_next    = acc_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        cnt_next    = cnt_reg;
        unique case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    if (op == 3'd7) begin
                        state_next  = EXEC;
                        acc_next    = '0;
                        mcand_next  = {{WIDTH{1'b0}}, a};
                        mplier_next = b;
                        cnt_next    = '0;
                    end else begin
                        state_next = DONE;
                        o_next     = alu_res;
                        flags_next = {alu_c, alu_v, alu_res[WIDTH-1], alu_res == '0};
                    end
                end
            end
            EXEC: begin
                acc_next    = acc_step;
                mcand_next  = mcand_reg << 1;
                mplier_next = mplier_reg >> 1;
                cnt_next    = cnt_reg + 1'b1;
                // Last multiplier bit: publish the folded-in product directly.
                if (cnt_reg == SW'(WIDTH - 1)) begin
                    state_next = DONE;
                    o_next     = acc_step[WIDTH-1:0];
                    flags_next = {|acc_step[2*WIDTH-1:WIDTH], 1'b0,
                                  acc_step[WIDTH-1], acc_step[WIDTH-1:0] == '0};
                end
            end
            DONE: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            o_reg      <= '0;
            flags_reg  <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            o_reg      <= o_next;
            flags_reg  <= flags_next;
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            cnt_reg    <= cnt_next;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign o         = o_reg;
    assign flags     = flags_reg;

endmodule

// File: tb/tb_alu_mc.sv
// Randomized and directed bench for alu_mc against an arithmetic reference model.
module tb_alu_mc;
    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] o;
    logic [3:0]   flags;

    int n_tests = 0;
    int n_fail  = 0;

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o         (o),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Returns {C, V, N, Z, result}, derived from integer arithmetic on the operands.
    function automatic logic [W+3:0] model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                          input logic [2:0] xop);
        longint ua, ub, m, sa, sb, full, r, s;
        bit c, v;
        ua = longint'(xa);
        ub = longint'(xb);
        m  = longint'(1) << W;
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        c  = 1'b0;
        v  = 1'b0;
        r  = 0;
        case (xop)
            3'd0: begin
                full = ua + ub; r = full % m; c = (full >= m);
                s = sa + sb; v = (s < -(m / 2)) || (s >= m / 2);
            end
            3'd1: begin
                full = ua - ub; r = (full + m) % m; c = (ua < ub);
                s = sa - sb; v = (s < -(m / 2)) || (s >= m / 2);
            end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua ^ ub;
            3'd5: r = (ua << (ub % W)) % m;
            3'd6: r = ua >> (ub % W);
            default: begin
                full = ua * ub; r = full % m; c = (full >= m);
            end
        endcase
        return {c, v, r >= m / 2, r == 0, W'(r)};
    endfunction

    // Caller is at a negedge with the DUT idle.
    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic [2:0] xop, input int hold);
        logic [W+3:0] e;
        int lat;
        e = model(xa, xb, xop);
        check_eq("in_ready_idle", 32'(in_ready), 32'd1);
        a = xa; b = xb; op = xop; in_valid = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        lat = 0;
        while (1) begin
            @(negedge clk);
            if (out_valid || lat > 20) break;
            check_eq("in_ready_busy", 32'(in_ready), 32'd0);
            lat++;
            in_valid = 1'($urandom);
            a = W'($urandom); b = W'($urandom); op = 3'($urandom);
        end
        if (!out_valid) begin
            check_eq("out_valid_timeout", 32'(out_valid), 32'd1);
            in_valid = 1'b0;
            return;
        end
        check_eq("latency", 32'(lat), (xop == 3'd7) ? 32'(W) : 32'd0);
        check_eq("o", 32'(o), 32'(e[W-1:0]));
        check_eq("flags", 32'(flags), 32'(e[W+3:W]));
        $display("[TB] op=%0d a=%02h b=%02h -> o=%02h flags=%b lat=%0d hold=%0d",
                 xop, xa, xb, o, flags, lat, hold);
        in_valid = 1'b0;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a = W'($urandom); b = W'($urandom); op = 3'($urandom);
            @(negedge clk);
            check_eq("hold_valid", 32'(out_valid), 32'd1);
            check_eq("hold_ready", 32'(in_ready), 32'd0);
            check_eq("hold_o", 32'(o), 32'(e[W-1:0]));
            check_eq("hold_flags", 32'(flags), 32'(e[W+3:W]));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("drop_valid", 32'(out_valid), 32'd0);
        check_eq("back_idle", 32'(in_ready), 32'd1);
        check_eq("retain_o", 32'(o), 32'(e[W-1:0]));
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b1;
        a = 8'h12; b = 8'h34; op = 3'd0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_o", 32'(o), 32'd0);
        check_eq("rst_flags", 32'(flags), 32'd0);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;

        do_op(8'hF0, 8'h20, 3'd0, 0);
        do_op(8'h80, 8'h01, 3'd1, 0);
        do_op(8'h01, 8'h02, 3'd1, 1);
        do_op(8'h10, 8'h11, 3'd7, 0);
        do_op(8'h0F, 8'h0F, 3'd7, 2);
        do_op(8'h81, 8'h09, 3'd5, 0);
        do_op(8'h0F, 8'hF0, 3'd2, 0);
        do_op(8'hA5, 8'h08, 3'd6, 0);
        do_op(8'h7F, 8'h01, 3'd0, 0);
        do_op(8'h3C, 8'h5A, 3'd4, 5);
        do_op(8'hFF, 8'hFF, 3'd7, 0);

        // Async reset in the middle of a multiply.
        a = 8'h10; b = 8'h11; op = 3'd7; in_valid = 1'b1;
        @(posedge clk);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_o", 32'(o), 32'd0);
        check_eq("midrst_flags", 32'(flags), 32'd0);
        check_eq("midrst_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; a = 8'h55; b = 8'h66; op = 3'd0;
        repeat (2) @(negedge clk);
        check_eq("inrst_o", 32'(o), 32'd0);
        check_eq("inrst_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        do_op(8'h01, 8'h01, 3'd0, 0);

        for (int i = 0; i < 150; i++) begin
            do_op(W'($urandom), W'($urandom), 3'($urandom), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
